timekeeper_core: RTL and testbench

//  Parametrised hh:mm:ss time-of-day counter with an internal prescaler from clk to 1 Hz.

---
 rtl/timekeeper_core.sv | 173 +++++++++++++++++
 tb/tb_timekeeper_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/timekeeper_core.sv
// Time-of-day counter: prescaler from clk to 1 Hz, hh:mm:ss with load/validate, set-mode nudges,
// 12/24 h display, optional packed-BCD buses and nested rollover pulses.
//
// state | meaning
// IDLE  | time held, prescaler held
// RUN   | prescaler counts, time advances at terminal count
// SET   | counting halted, inc_min/inc_hr nudge the time
module timekeeper_core #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int CNT_W         = 8,
   parameter bit BCD_OUT       = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_set_mode,
   input  logic             i_inc_min,
   input  logic             i_inc_hr,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_hr,
   input  logic [CNT_W-1:0] i_load_min,
   input  logic [CNT_W-1:0] i_load_sec,
   input  logic             i_mode_12h,
   output logic [CNT_W-1:0] o_countSec,
   output logic [CNT_W-1:0] o_countMin,
   output logic [CNT_W-1:0] o_countHr,
   output logic             o_pm,
   output logic             o_sec_pulse,
   output logic             o_min_pulse,
   output logic             o_hr_pulse,
   output logic             o_day_pulse,
   output logic             o_load_err,
   output logic [1:0]       o_state
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_SET = 2'b10} state_t;

   state_t        r_state, w_state_nxt;
   logic [PW-1:0] r_presc;
   logic [4:0]    r_hr;
   logic [5:0]    r_min, r_sec;
   logic          r_sec_p, r_min_p, r_hr_p, r_day_p, r_load_err;

   // Load buses decoded to binary; wide binary values saturate so they fail the range check
   function automatic logic [7:0] f_dec(input logic [CNT_W-1:0] v);
      logic [15:0] x;
      x = 16'(v);
      if (BCD_OUT) f_dec = 8'(x[7:4]) * 8'd10 + 8'(x[3:0]);
      else         f_dec = (x > 16'd255) ? 8'hFF : x[7:0];
   endfunction

   function automatic logic f_dig_ok(input logic [CNT_W-1:0] v);
      logic [15:0] x;
      x = 16'(v);
      f_dig_ok = !BCD_OUT || (x[15:8] == 8'd0 && x[7:4] <= 4'd9 && x[3:0] <= 4'd9);
   endfunction

   function automatic logic [CNT_W-1:0] f_enc(input logic [5:0] v);
      logic [7:0] b;
      b = {4'(v / 6'd10), 4'(v % 6'd10)};
      if (BCD_OUT) f_enc = CNT_W'(b);
      else         f_enc = CNT_W'(v);
   endfunction

   logic [7:0] w_ld_hr, w_ld_min, w_ld_sec;
   logic       w_load_ok, w_load_go, w_tick, w_presc_clr;
   logic [5:0] w_hr_disp;

   assign w_ld_hr   = f_dec(i_load_hr);
   assign w_ld_min  = f_dec(i_load_min);
   assign w_ld_sec  = f_dec(i_load_sec);
   assign w_load_ok = f_dig_ok(i_load_hr) && f_dig_ok(i_load_min) && f_dig_ok(i_load_sec)
                      && (w_ld_hr <= 8'd23) && (w_ld_min <= 8'd59) && (w_ld_sec <= 8'd59);
   assign w_load_go = i_load && w_load_ok;
   assign w_tick    = (r_state == ST_RUN) && (r_presc == TC);
   // Clear on SET entry and while in SET so leaving SET always starts a full second
   assign w_presc_clr = w_load_go || (r_state == ST_SET) || (w_state_nxt == ST_SET);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (i_set_mode) w_state_nxt = ST_SET;
                  else if (i_enable) w_state_nxt = ST_RUN;
         ST_RUN:  if (i_set_mode) w_state_nxt = ST_SET;
                  else if (!i_enable) w_state_nxt = ST_IDLE;
         ST_SET:  if (!i_set_mode) w_state_nxt = i_enable ? ST_RUN : ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_presc    <= '0;
         r_hr       <= '0;
         r_min      <= '0;
         r_sec      <= '0;
         r_sec_p    <= 1'b0;
         r_min_p    <= 1'b0;
         r_hr_p     <= 1'b0;
         r_day_p    <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_sec_p    <= 1'b0;
         r_min_p    <= 1'b0;
         r_hr_p     <= 1'b0;
         r_day_p    <= 1'b0;
         r_load_err <= i_load && !w_load_ok;

         if (w_presc_clr)            r_presc <= '0;
         else if (r_state == ST_RUN) r_presc <= w_tick ? '0 : r_presc + PW'(1);

         if (w_load_go) begin
            r_hr  <= w_ld_hr[4:0];
            r_min <= w_ld_min[5:0];
            r_sec <= w_ld_sec[5:0];
         end else if (w_tick) begin
            r_sec_p <= 1'b1;
            if (r_sec == 6'd59) begin
               r_sec   <= '0;
               r_min_p <= 1'b1;
               if (r_min == 6'd59) begin
                  r_min  <= '0;
                  r_hr_p <= 1'b1;
                  if (r_hr == 5'd23) begin
                     r_hr    <= '0;
                     r_day_p <= 1'b1;
                  end else begin
                     r_hr <= r_hr + 5'd1;
                  end
               end else begin
                  r_min <= r_min + 6'd1;
               end
            end else begin
               r_sec <= r_sec + 6'd1;
            end
         end else if (r_state == ST_SET) begin
            if (i_inc_min) begin
               r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
               r_sec <= '0;
            end
            if (i_inc_hr) r_hr <= (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
         end
      end
   end

   always_comb begin
      w_hr_disp = {1'b0, r_hr};
      if (i_mode_12h) begin
         if (r_hr == 5'd0)       w_hr_disp = 6'd12;
         else if (r_hr > 5'd12)  w_hr_disp = {1'b0, r_hr - 5'd12};
      end
   end

   assign o_countSec  = f_enc(r_sec);
   assign o_countMin  = f_enc(r_min);
   assign o_countHr   = f_enc(w_hr_disp);
   assign o_pm        = (r_hr >= 5'd12);
   assign o_sec_pulse = r_sec_p;
   assign o_min_pulse = r_min_p;
   assign o_hr_pulse  = r_hr_p;
   assign o_day_pulse = r_day_p;
   assign o_load_err  = r_load_err;
   assign o_state     = r_state;

endmodule

// File: tb/tb_timekeeper_core.sv
// Bench for timekeeper_core: directed scenarios then random stimulus, checked every cycle against
// a seconds-of-day reference model; a second instance covers the packed-BCD encoding.
module tb_timekeeper_core;
   localparam int TPS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1, en = 1'b0, sm = 1'b0, im = 1'b0, ih = 1'b0, ld = 1'b0, m12 = 1'b0;
   logic [7:0] lh = '0, lm = '0, ls = '0;
   logic [7:0] o_sec, o_min, o_hr;
   logic       o_pm, o_sp, o_mp, o_hp, o_dp, o_err;
   logic [1:0] o_st;

   logic       b_ld = 1'b0;
   logic [7:0] b_lh = '0, b_lm = '0, b_ls = '0;
   logic [7:0] b_sec, b_min, b_hr;
   logic       b_pm, b_sp, b_mp, b_hp, b_dp, b_err;
   logic [1:0] b_st;

   int checks = 0, failures = 0;

   int m_st = 0, m_t = 0, m_ps = 0;
   logic m_sp = 0, m_mp = 0, m_hp = 0, m_dp = 0, m_err = 0;

   always #5 clk = ~clk;

   timekeeper_core #(.TICKS_PER_SEC(TPS), .CNT_W(8), .BCD_OUT(1'b0)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_set_mode(sm), .i_inc_min(im), .i_inc_hr(ih),
      .i_load(ld), .i_load_hr(lh), .i_load_min(lm), .i_load_sec(ls), .i_mode_12h(m12),
      .o_countSec(o_sec), .o_countMin(o_min), .o_countHr(o_hr), .o_pm(o_pm),
      .o_sec_pulse(o_sp), .o_min_pulse(o_mp), .o_hr_pulse(o_hp), .o_day_pulse(o_dp),
      .o_load_err(o_err), .o_state(o_st));

   timekeeper_core #(.TICKS_PER_SEC(TPS), .CNT_W(8), .BCD_OUT(1'b1)) u_bcd (
      .i_clk(clk), .i_reset(rst), .i_enable(1'b0), .i_set_mode(1'b0), .i_inc_min(1'b0), .i_inc_hr(1'b0),
      .i_load(b_ld), .i_load_hr(b_lh), .i_load_min(b_lm), .i_load_sec(b_ls), .i_mode_12h(1'b1),
      .o_countSec(b_sec), .o_countMin(b_min), .o_countHr(b_hr), .o_pm(b_pm),
      .o_sec_pulse(b_sp), .o_min_pulse(b_mp), .o_hr_pulse(b_hp), .o_day_pulse(b_dp),
      .o_load_err(b_err), .o_state(b_st));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: time kept as seconds since midnight
   task automatic model_step();
      int   h, mi, s, nst;
      logic valid, tick;
      if (rst) begin
         m_st = 0; m_t = 0; m_ps = 0;
         {m_sp, m_mp, m_hp, m_dp, m_err} = '0;
         return;
      end
      nst = m_st;
      if (m_st == 0)      begin if (sm) nst = 2; else if (en) nst = 1; end
      else if (m_st == 1) begin if (sm) nst = 2; else if (!en) nst = 0; end
      else if (!sm)       nst = en ? 1 : 0;
      valid = (lh < 24) && (lm < 60) && (ls < 60);
      tick  = (m_st == 1) && (m_ps == TPS - 1);
      {m_sp, m_mp, m_hp, m_dp} = '0;
      m_err = ld && !valid;
      if (ld && valid) begin
         m_t = int'(lh) * 3600 + int'(lm) * 60 + int'(ls);
      end else if (tick) begin
         m_t  = (m_t + 1) % 86400;
         m_sp = 1'b1;
         m_mp = (m_t % 60 == 0);
         m_hp = (m_t % 3600 == 0);
         m_dp = (m_t == 0);
      end else if (m_st == 2) begin
         h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
         if (im) begin mi = (mi + 1) % 60; s = 0; end
         if (ih) h = (h + 1) % 24;
         m_t = h * 3600 + mi * 60 + s;
      end
      if ((ld && valid) || nst == 2 || m_st == 2) m_ps = 0;
      else if (m_st == 1)                          m_ps = (m_ps + 1) % TPS;
      m_st = nst;
   endtask

   task automatic cyc();
      int h;
      @(posedge clk);
      model_step();
      @(negedge clk);
      h = m_t / 3600;
      chk("sec", o_sec, m_t % 60);
      chk("min", o_min, (m_t / 60) % 60);
      chk("hr", o_hr, m12 ? ((h + 11) % 12) + 1 : h);
      chk("pm", o_pm, h >= 12);
      chk("pulses_err", {o_sp, o_mp, o_hp, o_dp, o_err}, {m_sp, m_mp, m_hp, m_dp, m_err});
      chk("state", o_st, m_st);
   endtask

   initial begin
      rst = 1'b1;
      cyc();
      chk("reset_state", o_st, 2'b00);
      rst = 1'b0; en = 1'b1;
      cyc();
      chk("run_entry", o_st, 2'b01);
      repeat (3) cyc();
      chk("first_sec_early", o_sec, 0);
      cyc();
      chk("first_sec", {o_sec, o_sp}, {8'd1, 1'b1});
      cyc();
      chk("sec_pulse_one_cycle", o_sp, 1'b0);

      ld = 1'b1; lh = 8'd23; lm = 8'd59; ls = 8'd58;
      cyc();
      ld = 1'b0;
      repeat (8) cyc();
      chk("day_wrap", {o_hr, o_min, o_sec, o_sp, o_mp, o_hp, o_dp}, {24'd0, 4'b1111});

      ld = 1'b1; lh = 8'd24; lm = 8'd0; ls = 8'd0;
      cyc();
      chk("bad_load_err", {o_err, o_st, o_hr}, {1'b1, 2'b01, 8'd0});
      ld = 1'b0;
      cyc();
      chk("bad_load_err_clear", o_err, 1'b0);

      m12 = 1'b1; ld = 1'b1; lh = 8'd0; lm = 8'd0; ls = 8'd0;
      cyc();
      chk("12h_midnight", {o_hr, o_pm}, {8'd12, 1'b0});
      lh = 8'd13; lm = 8'd5;
      cyc();
      chk("12h_pm", {o_hr, o_pm}, {8'd1, 1'b1});

      m12 = 1'b0; en = 1'b0; lh = 8'd23; lm = 8'd59; ls = 8'd30;
      cyc();
      ld = 1'b0; sm = 1'b1;
      cyc();
      chk("set_entry", o_st, 2'b10);
      im = 1'b1;
      cyc();
      chk("inc_min", {o_hr, o_min, o_sec}, {8'd23, 8'd0, 8'd0});
      im = 1'b0; ih = 1'b1;
      cyc();
      chk("inc_hr", {o_hr, o_min, o_sec, o_sp}, {24'd0, 1'b0});
      ih = 1'b0; sm = 1'b0;
      cyc();
      chk("set_exit_idle", o_st, 2'b00);

      rst = 1'b1;
      cyc();
      rst = 1'b0; en = 1'b1;
      repeat (3) cyc();
      en = 1'b0;
      repeat (5) cyc();
      en = 1'b1;
      cyc();
      chk("resume_no_tick", o_sec, 0);
      cyc();
      chk("resume_tick", {o_sec, o_sp}, {8'd1, 1'b1});
      repeat (2) cyc();
      rst = 1'b1;
      cyc();
      chk("reset_mid_run", {o_st, o_hr, o_min, o_sec}, 26'd0);
      rst = 1'b0;

      b_ld = 1'b1; b_lh = 8'h13; b_lm = 8'h05; b_ls = 8'h59;
      cyc();
      chk("bcd_load", {b_hr, b_min, b_sec, b_pm, b_err}, {8'h01, 8'h05, 8'h59, 1'b1, 1'b0});
      b_lh = 8'h1A;
      cyc();
      chk("bcd_bad_digit", {b_err, b_hr}, {1'b1, 8'h01});
      b_lh = 8'h00; b_ls = 8'h6A;
      cyc();
      chk("bcd_bad_sec", {b_err, b_hr, b_sec}, {1'b1, 8'h01, 8'h59});
      b_ls = 8'h07;
      cyc();
      chk("bcd_midnight_12h", {b_hr, b_sec, b_pm, b_err, b_st}, {8'h12, 8'h07, 1'b0, 1'b0, 2'b00});
      b_lh = 8'h22; b_lm = 8'h41; b_ls = 8'h00;
      cyc();
      chk("bcd_evening", {b_hr, b_min, b_pm, b_sp, b_mp, b_hp, b_dp}, {8'h10, 8'h41, 1'b1, 4'b0000});
      b_ld = 1'b0;

      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) sm = ~sm;
         im  = ($urandom_range(0, 3) == 0);
         ih  = ($urandom_range(0, 3) == 0);
         ld  = ($urandom_range(0, 49) == 0);
         lh  = 8'($urandom_range(0, 27));
         lm  = 8'($urandom_range(0, 63));
         ls  = 8'($urandom_range(0, 63));
         if ($urandom_range(0, 29) == 0) m12 = ~m12;
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
